t05_regfile_write_arbiter: RTL and testbench
============================================

// Module: t05_regfile_write_arbiter
// PURPOSE
// - Shares the single register-file write port between two writeback requesters: req0 (ALU) and req1 (load unit).
// - Round-robin arbitration feeds a registered write stage that drives the register file's write/rd/reg_write inputs.
// - Holds a pending-destination scoreboard so issue logic can stall RAW and WAW hazards until the write lands.
// PARAMETERS
// - DATA_W  32  write data width
// - ADDR_W  5   register index width (2**ADDR_W registers; index 0 is hardwired zero)
// PORTS
// - clk           in   1       clock, all state on posedge
// - rst           in   1       synchronous active-high reset
// - req0_valid    in   1       ALU writeback request
// - req0_rd       in   ADDR_W  ALU destination register
// - req0_data     in   DATA_W  ALU result
// - req0_ready    out  1       ALU request accepted this cycle
// - req1_valid    in   1       load-unit writeback request
// - req1_rd       in   ADDR_W  load destination register
// - req1_data     in   DATA_W  load data
// - req1_ready    out  1       load request accepted this cycle
// - issue_valid   in   1       an instruction with destination issue_rd is issuing
// - issue_rd      in   ADDR_W  destination of the issuing instruction
// - issue_ready   out  1       issue permitted (no WAW conflict)
// - rs1, rs2      in   ADDR_W  source registers of the instruction in decode
// - hazard        out  1       rs1 or rs2 has a pending write
// - write         out  1       register file write enable (registered)
// - rd            out  ADDR_W  register file write index (registered)
// - reg_write     out  DATA_W  register file write data (registered)
// - pending_cnt   out  ADDR_W+1  number of set scoreboard bits
// BEHAVIOUR
// - Reset: write=0, rd=0, reg_write=0, pending all 0 (pending_cnt=0), last_grant=1 (req0 wins the first tie).
// - Arbitration (combinational):
//   - With only one valid request, that requester is granted.
//   - With both valid, the requester not in last_grant is granted.
//   - reqN_ready equals grantN. Exactly one grant at most. ready never depends on the requester's own ready.
// - Accept (grant & valid):
//   - last_grant takes the granted index.
//   - Next cycle: write=1, rd=req rd, reg_write=req data.
//   - An accepted request with rd==0 produces write=0 (data dropped, no scoreboard effect).
// - With no accept, write=0 next cycle; rd and reg_write hold their last values.
// - Latency: accept at cycle N, register file written at the edge ending cycle N+1. A requester may be accepted back-to-back every cycle.
// - Scoreboard, set: issue_valid & issue_ready & issue_rd!=0 sets pending[issue_rd].
// - Scoreboard, clear: write=1 (output stage) clears pending[rd] at the same edge the register file captures data.
// - Same index set and cleared in one cycle: set wins (the new producer is outstanding).
// - issue_ready = (issue_rd==0) | ~pending[issue_rd] | (write & rd==issue_rd).
// - hazard = (rs1!=0 & pending[rs1]) | (rs2!=0 & pending[rs2]). No bypassing: hazard is still 1 during the cycle write=1 for that rd and drops the next cycle.
// - pending_cnt = popcount(pending), updated with the bits.
// - A writeback to a non-pending rd is legal: it is written, and the scoreboard is unchanged.
// - Reset mid-operation: any accepted but unwritten request is discarded (write=0 after reset) and all pending bits clear.
// TESTING
// - Reset: assert rst with both requests valid -> write=0, pending_cnt=0; after release, req0 is granted first.
// - Contention: req0 and req1 held valid 4 cycles (rd 3 and 4) -> grants alternate 0,1,0,1; write=1 on 4 consecutive cycles with rd 3,4,3,4.
// - Latency: req1_valid rd=7 data=0xDEADBEEF at cycle N -> req1_ready=1 at N; write=1, rd=7, reg_write=0xDEADBEEF at N+1.
// - Scoreboard: issue rd=5, then rs1=5 -> hazard=1 until the cycle after write=1 with rd=5; pending_cnt goes 1 then 0.
// - WAW: issue rd=9 twice with no writeback -> second issue_ready=0. With the writeback of rd 9 in the same cycle -> issue_ready=1 and pending[9] stays set.
// - x0: req0 rd=0 accepted -> write=0; issue rd=0 -> issue_ready=1, pending_cnt unchanged; rs1=0 never raises hazard.

Source files
------------

// File: rtl/t05_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// t05_regfile_write_arbiter
//
// Purpose:
//   Two writeback requesters share the single register-file write port:
//   req0 is the ALU and req1 is the load unit. A round-robin arbiter picks one
//   request per cycle. The winner is captured in a registered write stage,
//   which drives the register file's write / rd / reg_write inputs.
//
//   A pending-destination scoreboard tracks every issued instruction whose
//   result has not been written yet. Issue logic uses it in two ways:
//     - hazard      : stall decode on RAW hazards.
//     - issue_ready : stall issue on WAW hazards.
//   A scoreboard bit clears on the same edge that the register file captures
//   the data.
//
// Parameters:
//   DATA_W  write data width
//   ADDR_W  register index width (2**ADDR_W registers, index 0 reads as zero)
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req0_valid/rd/data, req0_ready  ALU writeback request / accept
//   req1_valid/rd/data, req1_ready  load-unit writeback request / accept
//   issue_valid, issue_rd           instruction issuing with destination issue_rd
//   issue_ready                     issue permitted (no WAW conflict)
//   rs1, rs2                        decode-stage source registers
//   hazard                          rs1 or rs2 has an outstanding write
//   write, rd, reg_write            registered register-file write port
//   pending_cnt                     number of outstanding destinations
// -----------------------------------------------------------------------------
module t05_regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,

    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,

    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              hazard,

    output logic              write,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] reg_write,

    output logic [ADDR_W:0]   pending_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic            last_grant;   // index of the requester granted most recently
    logic [NREG-1:0] pending;      // one bit per destination awaiting writeback

    // -------------------------------------------------------------------------
    // Round-robin arbitration
    // -------------------------------------------------------------------------
    // A lone request always wins. When both requests are valid, the requester
    // that was not granted last time wins. The grants depend only on the
    // valids and last_grant, never on the ready outputs, so there is no
    // combinational loop through a requester that waits for ready.
    logic            grant0;
    logic            grant1;
    logic            accept;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    // NOTE: every signal written in an always_comb gets a default value at the
    // top of the block. This way no path leaves it unassigned, which would
    // otherwise infer a latch.
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        sel_rd   = '0;
        sel_data = '0;

        if (req0_valid && req1_valid) begin
            grant0 = last_grant;        // req1 won last time -> req0's turn
            grant1 = ~last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end

        if (grant1) begin
            sel_rd   = req1_rd;
            sel_data = req1_data;
        end else begin
            sel_rd   = req0_rd;
            sel_data = req0_data;
        end
    end

    assign accept     = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // -------------------------------------------------------------------------
    // Scoreboard lookups
    // -------------------------------------------------------------------------
    // The output stage clears its destination at the end of this cycle.
    // Because of that, a new producer of the same register may issue now:
    // its set lands on the same edge and wins over the clear.
    logic write_hits_issue;
    logic set_en;

    assign write_hits_issue = write && (rd == issue_rd);

    assign issue_ready = (issue_rd == '0) || !pending[issue_rd] || write_hits_issue;

    assign set_en = issue_valid && issue_ready && (issue_rd != '0);

    // There is no bypass from the write stage. A source stays hazardous until
    // the cycle after its write, when the register file holds the new value.
    assign hazard = ((rs1 != '0) && pending[rs1]) ||
                    ((rs2 != '0) && pending[rs2]);

    // Next scoreboard contents. The clear is applied first and the set second,
    // so a same-index set and clear leaves the bit set.
    logic [NREG-1:0] pending_nxt;

    always_comb begin
        pending_nxt = pending;
        if (write) begin
            pending_nxt[rd] = 1'b0;
        end
        if (set_en) begin
            pending_nxt[issue_rd] = 1'b1;
        end
    end

    // Population count of the scoreboard register, so the count tracks the
    // bits exactly.
    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            pending_cnt = pending_cnt + (ADDR_W + 1)'(pending[i]);
        end
    end

    // -------------------------------------------------------------------------
    // Registered write stage, arbiter pointer and scoreboard
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only.
    // Every flop then samples values from before the edge, whatever order the
    // statements are written in.
    always_ff @(posedge clk) begin
        if (rst) begin
            // A request accepted in the cycle of reset is discarded.
            write      <= 1'b0;
            rd         <= '0;
            reg_write  <= '0;
            last_grant <= 1'b1;          // req0 wins the first tie
            pending    <= '0;
        end else begin
            // A write to x0 is dropped here and never reaches the register
            // file or the scoreboard.
            write <= accept && (sel_rd != '0);
            if (accept) begin
                rd         <= sel_rd;
                reg_write  <= sel_data;
                last_grant <= grant1;
            end
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_t05_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_t05_regfile_write_arbiter
//
// Self-checking bench for t05_regfile_write_arbiter. A behavioural model
// predicts every output of every checked cycle:
//   - the arbiter as "whose turn it is",
//   - the write stage as a one-deep delayed copy of the accepted request,
//   - the scoreboard as an array of outstanding destinations.
// The bench runs directed scenarios first, then randomized traffic with
// occasional resets.
// -----------------------------------------------------------------------------
module tb_t05_regfile_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid, issue_valid;
    logic [ADDR_W-1:0] req0_rd, req1_rd, issue_rd, rs1, rs2;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready, issue_ready, hazard, write;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] reg_write;
    logic [ADDR_W:0]   pending_cnt;

    always #5 clk = ~clk;

    t05_regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_rd     (req0_rd),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_rd     (req1_rd),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard      (hazard),
        .write       (write),
        .rd          (rd),
        .reg_write   (reg_write),
        .pending_cnt (pending_cnt)
    );

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    int              m_last;        // requester served most recently (0/1)
    bit              m_pend[NREG];  // outstanding destinations
    bit              m_write;       // a write is presented this cycle
    int              m_rd;
    logic [31:0]     m_data;

    // Evaluated at the negedge, consumed at the posedge.
    int              e_grant;       // -1 = nobody granted
    bit              e_iready;

    // Observations captured at the negedge, for directed checks.
    logic            o_r0, o_r1, o_write, o_iready, o_hazard;
    logic [ADDR_W-1:0] o_rd;
    logic [31:0]     o_data;
    logic [ADDR_W:0] o_cnt;

    bit chk_en = 1'b0;

    task automatic model_reset();
        m_last  = 1;
        m_write = 1'b0;
        m_rd    = 0;
        m_data  = '0;
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
    endtask

    task automatic model_eval();
        int cnt;
        bit hz;
        int ird;
        int s1;
        int s2;
        ird = int'(issue_rd);
        s1  = int'(rs1);
        s2  = int'(rs2);

        if (req0_valid && req1_valid) e_grant = 1 - m_last;
        else if (req0_valid)          e_grant = 0;
        else if (req1_valid)          e_grant = 1;
        else                          e_grant = -1;

        e_iready = (ird == 0) || !m_pend[ird] || (m_write && m_rd == ird);
        hz  = (s1 != 0 && m_pend[s1]) || (s2 != 0 && m_pend[s2]);
        cnt = 0;
        for (int i = 0; i < NREG; i++) cnt += int'(m_pend[i]);

        o_r0 = req0_ready;   o_r1 = req1_ready;   o_write = write;
        o_rd = rd;           o_data = reg_write;  o_iready = issue_ready;
        o_hazard = hazard;   o_cnt = pending_cnt;

        if (chk_en) begin
            check("req0_ready",  64'(req0_ready),  64'(e_grant == 0));
            check("req1_ready",  64'(req1_ready),  64'(e_grant == 1));
            check("issue_ready", 64'(issue_ready), 64'(e_iready));
            check("hazard",      64'(hazard),      64'(hz));
            check("pending_cnt", 64'(pending_cnt), 64'(cnt));
            check("write",       64'(write),       64'(m_write));
            if (m_write) begin
                check("rd",        64'(rd),        64'(m_rd));
                check("reg_write", 64'(reg_write), 64'(m_data));
            end
        end
    endtask

    task automatic model_update();
        int ird;
        ird = int'(issue_rd);
        if (rst) begin
            model_reset();
        end else begin
            if (m_write) m_pend[m_rd] = 1'b0;
            if (issue_valid && e_iready && ird != 0) m_pend[ird] = 1'b1;
            if (e_grant >= 0) begin
                m_last  = e_grant;
                m_rd    = (e_grant == 0) ? int'(req0_rd) : int'(req1_rd);
                m_data  = (e_grant == 0) ? req0_data : req1_data;
                m_write = (m_rd != 0);
            end else begin
                m_write = 1'b0;
            end
        end
    endtask

    // One clock cycle: the inputs are already driven. Check at the negedge,
    // advance the model at the posedge, then return #1 after it.
    task automatic step();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
        req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
        issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] exp_rd_seq[4];
    int cnt_before;

    initial begin
        exp_rd_seq[0] = 5'd3; exp_rd_seq[1] = 5'd4;
        exp_rd_seq[2] = 5'd3; exp_rd_seq[3] = 5'd4;

        idle();
        model_reset();

        // Reset with both requests valid. The first cycle is unchecked because
        // the DUT state is still unknown.
        rst = 1'b1;
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h0000_0003;
        req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h0000_0004;
        @(posedge clk); #1;
        model_reset();
        chk_en = 1'b1;
        step();                                     // still in reset
        check("rst_write", 64'(o_write), 64'(0));
        check("rst_cnt",   64'(o_cnt),   64'(0));

        // Contention: grants alternate 0,1,0,1 starting with req0.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_grant0", 64'(o_r0), 64'(i % 2 == 0));
            check("rr_grant1", 64'(o_r1), 64'(i % 2 == 1));
            if (i > 0) begin
                check("rr_write", 64'(o_write), 64'(1));
                check("rr_rd",    64'(o_rd),    64'(exp_rd_seq[i-1]));
            end
        end
        idle();
        step();
        check("rr_write_last", 64'(o_write), 64'(1));
        check("rr_rd_last",    64'(o_rd),    64'(exp_rd_seq[3]));
        step();
        check("rr_idle_write", 64'(o_write), 64'(0));

        // Latency: load to x7.
        req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'hDEAD_BEEF;
        step();
        check("lat_ready1", 64'(o_r1), 64'(1));
        idle();
        step();
        check("lat_write", 64'(o_write), 64'(1));
        check("lat_rd",    64'(o_rd),    64'(7));
        check("lat_data",  64'(o_data),  64'(32'hDEAD_BEEF));

        // Scoreboard / RAW on x5.
        issue_valid = 1'b1; issue_rd = 5'd5;
        step();
        idle();
        rs1 = 5'd5;
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h5555_5555;
        step();                                     // accept
        check("raw_hazard_set", 64'(o_hazard), 64'(1));
        check("raw_cnt_1",      64'(o_cnt),    64'(1));
        req0_valid = 1'b0;
        step();                                     // write=1, rd=5
        check("raw_write",          64'(o_write),  64'(1));
        check("raw_hazard_at_write", 64'(o_hazard), 64'(1));
        step();
        check("raw_hazard_clr", 64'(o_hazard), 64'(0));
        check("raw_cnt_0",      64'(o_cnt),    64'(0));
        idle();

        // WAW on x9.
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        step();
        check("waw_blocked", 64'(o_iready), 64'(0));
        issue_valid = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h9999_0000;
        step();
        req0_valid = 1'b0;
        issue_valid = 1'b1;
        step();                                     // write of x9 + reissue
        check("waw_same_cycle", 64'(o_iready), 64'(1));
        issue_valid = 1'b0;
        step();
        check("waw_still_pend", 64'(o_cnt), 64'(1));
        rs2 = 5'd9;
        step();
        check("waw_hazard", 64'(o_hazard), 64'(1));
        idle();

        // x0 handling.
        cnt_before = int'(o_cnt);
        req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'hFFFF_FFFF;
        step();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        step();
        check("x0_write",  64'(o_write),  64'(0));
        check("x0_iready", 64'(o_iready), 64'(1));
        check("x0_hazard", 64'(o_hazard), 64'(0));
        idle();
        step();
        check("x0_cnt", 64'(o_cnt), 64'(cnt_before));

        // Randomized traffic, small register range so that conflicts occur.
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            req0_valid  = $urandom_range(0, 1) == 1;
            req0_rd     = ADDR_W'($urandom_range(0, 7));
            req0_data   = $urandom;
            req1_valid  = $urandom_range(0, 1) == 1;
            req1_rd     = ADDR_W'($urandom_range(0, 7));
            req1_data   = $urandom;
            issue_valid = $urandom_range(0, 2) != 0;
            issue_rd    = ADDR_W'($urandom_range(0, 7));
            rs1         = ADDR_W'($urandom_range(0, 7));
            rs2         = ADDR_W'($urandom_range(0, 31));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
